dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter.sv | 162 ++++++++++++++++
 tb/tb_dmem_arbiter.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one data memory between port A (CPU) and port B.
// A has priority; B is promoted once it has lost STARVE_MAX times in a row.
module dmem_arbiter #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        inclk,
  input  logic        rstn,
  input  logic        a_req,
  input  logic        a_we,
  input  logic [31:0] a_addr,
  input  logic [31:0] a_wdata,
  output logic        a_done,
  output logic [31:0] a_rdata,
  input  logic        b_req,
  input  logic        b_we,
  input  logic [31:0] b_addr,
  input  logic [31:0] b_wdata,
  output logic        b_done,
  output logic [31:0] b_rdata,
  output logic        DM_CS,
  output logic        DM_R,
  output logic        DM_W,
  output logic [31:0] DM_addr,
  output logic [31:0] DM_wdata,
  input  logic [31:0] DM_rdata,
  output logic        busy,
  output logic        owner_b
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACC_A = 2'd1,
    ACC_B = 2'd2
  } state_e;

  localparam logic [3:0] SMAX = STARVE_MAX[3:0];

  state_e      state_q, state_d;
  logic [3:0]  wait_q, wait_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        owner_q, owner_d;
  logic        a_done_q, a_done_d;
  logic        b_done_q, b_done_d;
  logic [31:0] a_rdata_q, a_rdata_d;
  logic [31:0] b_rdata_q, b_rdata_d;
  logic        cs_q, cs_d;
  logic        rd_q, rd_d;
  logic        wr_q, wr_d;
  logic        grant_a, grant_b;

  // A wins by default; B wins alone or once it has starved long enough.
  always_comb begin
    grant_a = a_req & (~b_req | (wait_q < SMAX));
    grant_b = b_req & (~a_req | (wait_q >= SMAX));
  end

  // Next state, access latches, strobes, done pulses and read capture.
  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    owner_d   = owner_q;
    a_done_d  = 1'b0;
    b_done_d  = 1'b0;
    a_rdata_d = a_rdata_q;
    b_rdata_d = b_rdata_q;
    cs_d      = 1'b0;
    rd_d      = 1'b0;
    wr_d      = 1'b0;
    unique case (state_q)
      IDLE: begin
        unique case (1'b1)
          grant_a: begin
            state_d = ACC_A;
            we_d    = a_we;
            addr_d  = a_addr;
            wdata_d = a_wdata;
            owner_d = 1'b0;
          end
          grant_b: begin
            state_d = ACC_B;
            we_d    = b_we;
            addr_d  = b_addr;
            wdata_d = b_wdata;
            owner_d = 1'b1;
          end
          default: ;
        endcase
        cs_d = grant_a | grant_b;
        rd_d = cs_d & ~we_d;
        wr_d = cs_d & we_d;
        if (grant_b) begin
          wait_d = '0;
        end else if (grant_a & b_req & (wait_q != SMAX)) begin
          wait_d = wait_q + 4'd1;
        end
      end
      ACC_A: begin
        state_d  = IDLE;
        a_done_d = 1'b1;
        if (!we_q) a_rdata_d = DM_rdata;
      end
      ACC_B: begin
        state_d  = IDLE;
        b_done_d = 1'b1;
        if (!we_q) b_rdata_d = DM_rdata;
      end
      default: state_d = IDLE;
    endcase
    if (!b_req) wait_d = '0;
  end

  // State and registered outputs; reset drops every strobe at once.
  always_ff @(posedge inclk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      wait_q    <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      owner_q   <= 1'b0;
      a_done_q  <= 1'b0;
      b_done_q  <= 1'b0;
      a_rdata_q <= '0;
      b_rdata_q <= '0;
      cs_q      <= 1'b0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      owner_q   <= owner_d;
      a_done_q  <= a_done_d;
      b_done_q  <= b_done_d;
      a_rdata_q <= a_rdata_d;
      b_rdata_q <= b_rdata_d;
      cs_q      <= cs_d;
      rd_q      <= rd_d;
      wr_q      <= wr_d;
    end
  end

  assign a_done   = a_done_q;
  assign b_done   = b_done_q;
  assign a_rdata  = a_rdata_q;
  assign b_rdata  = b_rdata_q;
  assign DM_CS    = cs_q;
  assign DM_R     = rd_q;
  assign DM_W     = wr_q;
  assign DM_addr  = addr_q;
  assign DM_wdata = wdata_q;
  assign busy     = cs_q;
  assign owner_b  = owner_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed and randomized checks of dmem_arbiter
// against a transaction-level arbitration and memory model.
module tb_dmem_arbiter;

  localparam int SM = 4;

  logic        inclk = 1'b0;
  logic        rstn = 1'b0;
  logic        a_req = 0, a_we = 0;
  logic [31:0] a_addr = 0, a_wdata = 0;
  logic        b_req = 0, b_we = 0;
  logic [31:0] b_addr = 0, b_wdata = 0;
  logic        a_done, b_done, DM_CS, DM_R, DM_W, busy, owner_b;
  logic [31:0] a_rdata, b_rdata, DM_addr, DM_wdata, DM_rdata;

  int checks = 0;
  int errors = 0;

  always #5 inclk = ~inclk;

  dmem_arbiter #(.STARVE_MAX(SM)) dut (
    .inclk(inclk), .rstn(rstn),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_done(a_done), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_done(b_done), .b_rdata(b_rdata),
    .DM_CS(DM_CS), .DM_R(DM_R), .DM_W(DM_W),
    .DM_addr(DM_addr), .DM_wdata(DM_wdata), .DM_rdata(DM_rdata),
    .busy(busy), .owner_b(owner_b)
  );

  // Environment memory: 64 words, combinational read, preload port.
  logic [31:0] mem [0:63];
  logic        pl_en = 0;
  logic [5:0]  pl_idx = 0;
  logic [31:0] pl_val = 0;
  assign DM_rdata = mem[DM_addr[5:0]];
  always @(posedge inclk) begin
    if (pl_en) mem[pl_idx] <= pl_val;
    else if (DM_CS && DM_W) mem[DM_addr[5:0]] <= DM_wdata;
  end

  // Reference model: one pending access, whole-transaction view.
  logic [31:0] ref_mem [0:63];
  bit          m_busy, m_ob, m_we, m_ad, m_bd;
  logic [31:0] m_addr, m_wdata, m_ard, m_brd;
  int          m_wait;

  task automatic model_reset();
    m_busy = 0; m_ob = 0; m_we = 0; m_ad = 0; m_bd = 0;
    m_addr = 0; m_wdata = 0; m_ard = 0; m_brd = 0; m_wait = 0;
  endtask

  task automatic model_step(input bit ar, input bit aw,
                            input logic [31:0] aa, input logic [31:0] ad,
                            input bit br, input bit bw,
                            input logic [31:0] ba, input logic [31:0] bd);
    bit pick_b;
    m_ad = 0;
    m_bd = 0;
    if (m_busy) begin
      m_busy = 0;
      if (m_we) ref_mem[m_addr[5:0]] = m_wdata;
      else if (m_ob) m_brd = ref_mem[m_addr[5:0]];
      else m_ard = ref_mem[m_addr[5:0]];
      if (m_ob) m_bd = 1; else m_ad = 1;
      if (!br) m_wait = 0;
    end else if (ar || br) begin
      pick_b  = br && (!ar || m_wait >= SM);
      m_busy  = 1;
      m_ob    = pick_b;
      m_we    = pick_b ? bw : aw;
      m_addr  = pick_b ? ba : aa;
      m_wdata = pick_b ? bd : ad;
      if (!br || pick_b) m_wait = 0;
      else m_wait = (m_wait + 1 > SM) ? SM : m_wait + 1;
    end else begin
      m_wait = 0;
    end
  endtask

  // One clock: model consumes the inputs seen at the edge.
  task automatic tick();
    bit ar, aw, br, bw;
    logic [31:0] aa, ad, ba, bd;
    ar = a_req; aw = a_we; aa = a_addr; ad = a_wdata;
    br = b_req; bw = b_we; ba = b_addr; bd = b_wdata;
    @(posedge inclk);
    #1;
    if (!rstn) model_reset();
    else model_step(ar, aw, aa, ad, br, bw, ba, bd);
  endtask

  task automatic preload(input int idx, input logic [31:0] val);
    pl_en = 1; pl_idx = idx[5:0]; pl_val = val;
    tick();
    pl_en = 0;
    ref_mem[idx] = val;
  endtask

  task automatic test_reset();
    rstn = 0;
    for (int i = 0; i < 64; i++) preload(i, $urandom);
    #2 rstn = 1;
    checks++; if (DM_CS !== 1'b0) begin errors++; $display("FAIL reset_cs got %b want 0", DM_CS); end
    checks++; if (DM_R !== 1'b0) begin errors++; $display("FAIL reset_r got %b want 0", DM_R); end
    checks++; if (DM_W !== 1'b0) begin errors++; $display("FAIL reset_w got %b want 0", DM_W); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (owner_b !== 1'b0) begin errors++; $display("FAIL reset_owner got %b want 0", owner_b); end
    checks++; if ({a_done, b_done} !== 2'b00) begin errors++; $display("FAIL reset_done got %b want 00", {a_done, b_done}); end
    checks++; if (a_rdata !== 32'h0) begin errors++; $display("FAIL reset_ardata got %h want 0", a_rdata); end
    checks++; if (b_rdata !== 32'h0) begin errors++; $display("FAIL reset_brdata got %h want 0", b_rdata); end
    checks++; if (DM_addr !== 32'h0) begin errors++; $display("FAIL reset_addr got %h want 0", DM_addr); end
    checks++; if (DM_wdata !== 32'h0) begin errors++; $display("FAIL reset_wdata got %h want 0", DM_wdata); end
  endtask

  task automatic test_single_read();
    preload(16, 32'hDEADBEEF);
    a_req = 1; a_we = 0; a_addr = 32'h10; a_wdata = $urandom;
    tick();
    a_req = 0;
    checks++; if ({DM_CS, DM_R, DM_W} !== 3'b110) begin errors++; $display("FAIL rd_strobes got %b want 110", {DM_CS, DM_R, DM_W}); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rd_busy1 got %b want 1", busy); end
    checks++; if (DM_addr !== 32'h10) begin errors++; $display("FAIL rd_addr got %h want 10", DM_addr); end
    checks++; if (a_done !== 1'b0) begin errors++; $display("FAIL rd_early_done got %b want 0", a_done); end
    tick();
    checks++; if (a_done !== 1'b1) begin errors++; $display("FAIL rd_done got %b want 1", a_done); end
    checks++; if (a_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_data got %h want deadbeef", a_rdata); end
    checks++; if ({busy, DM_CS} !== 2'b00) begin errors++; $display("FAIL rd_busy2 got %b want 00", {busy, DM_CS}); end
    tick();
    checks++; if (a_done !== 1'b0) begin errors++; $display("FAIL rd_pulse got %b want 0", a_done); end
    checks++; if (a_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_hold got %h want deadbeef", a_rdata); end
  endtask

  task automatic test_back_to_back();
    b_req = 1; b_we = 1; b_addr = 32'h20; b_wdata = 32'h12345678;
    tick();
    checks++; if ({owner_b, DM_W, DM_R} !== 3'b110) begin errors++; $display("FAIL b2b_wr got %b want 110", {owner_b, DM_W, DM_R}); end
    tick();
    checks++; if (b_done !== 1'b1) begin errors++; $display("FAIL b2b_done1 got %b want 1", b_done); end
    b_we = 0;
    tick();
    checks++; if ({b_done, DM_R} !== 2'b01) begin errors++; $display("FAIL b2b_mid got %b want 01", {b_done, DM_R}); end
    tick();
    checks++; if (b_done !== 1'b1) begin errors++; $display("FAIL b2b_done2 got %b want 1", b_done); end
    checks++; if (b_rdata !== 32'h12345678) begin errors++; $display("FAIL b2b_data got %h want 12345678", b_rdata); end
    checks++; if (a_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL b2b_arodata got %h want deadbeef", a_rdata); end
    b_req = 0;
    tick();
  endtask

  task automatic test_starvation();
    bit exp_b [10];
    int n = 0;
    int t = 0;
    for (int i = 0; i < 10; i++) exp_b[i] = (i == 4 || i == 9);
    a_req = 1; b_req = 1; a_we = 0; b_we = 0;
    a_addr = $urandom_range(63); b_addr = $urandom_range(63);
    while (n < 10 && t < 60) begin
      tick();
      t++;
      if (busy === 1'b1) begin
        checks++;
        if (owner_b !== exp_b[n]) begin
          errors++;
          $display("FAIL starve_grant%0d got %b want %b", n, owner_b, exp_b[n]);
        end
        n++;
      end
    end
    checks++; if (n != 10) begin errors++; $display("FAIL starve_timeout got %0d want 10", n); end
    a_req = 0; b_req = 0;
    repeat (2) tick();
  endtask

  task automatic test_simultaneous();
    a_req = 1; b_req = 1; a_we = 0; b_we = 0;
    tick();
    a_req = 0;
    checks++; if ({busy, owner_b} !== 2'b10) begin errors++; $display("FAIL sim_first got %b want 10", {busy, owner_b}); end
    tick();
    checks++; if ({a_done, busy} !== 2'b10) begin errors++; $display("FAIL sim_adone got %b want 10", {a_done, busy}); end
    tick();
    checks++; if ({busy, owner_b} !== 2'b11) begin errors++; $display("FAIL sim_second got %b want 11", {busy, owner_b}); end
    tick();
    checks++; if (b_done !== 1'b1) begin errors++; $display("FAIL sim_bdone got %b want 1", b_done); end
    b_req = 0;
    tick();
  endtask

  task automatic test_reset_mid_write();
    preload(48, 32'h0BADF00D);
    a_req = 1; a_we = 1; a_addr = 32'h30; a_wdata = 32'hFFFFFFFF;
    tick();
    checks++; if (DM_W !== 1'b1) begin errors++; $display("FAIL rmw_w got %b want 1", DM_W); end
    #2 rstn = 0;
    a_req = 0;
    #1 model_reset();
    checks++; if ({DM_CS, DM_R, DM_W, busy, owner_b} !== 5'b0) begin errors++; $display("FAIL rmw_strobes got %b want 00000", {DM_CS, DM_R, DM_W, busy, owner_b}); end
    checks++; if ({a_rdata, b_rdata} !== 64'h0) begin errors++; $display("FAIL rmw_rdata got %h want 0", {a_rdata, b_rdata}); end
    checks++; if ({DM_addr, DM_wdata} !== 64'h0) begin errors++; $display("FAIL rmw_addr got %h want 0", {DM_addr, DM_wdata}); end
    tick();
    #2 rstn = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (a_done !== 1'b0) begin errors++; $display("FAIL rmw_done%0d got %b want 0", i, a_done); end
    end
    checks++; if (mem[48] !== 32'h0BADF00D) begin errors++; $display("FAIL rmw_mem got %h want 0badf00d", mem[48]); end
  endtask

  task automatic test_random();
    bit apend = 0;
    bit bpend = 0;
    int bad = 0;
    for (int c = 0; c < 400; c++) begin
      if (!apend && $urandom_range(2) == 0) begin
        apend = 1; a_req = 1; a_we = $urandom_range(1);
        a_addr = $urandom_range(63); a_wdata = $urandom;
      end
      if (!bpend && $urandom_range(2) == 0) begin
        bpend = 1; b_req = 1; b_we = $urandom_range(1);
        b_addr = $urandom_range(63); b_wdata = $urandom;
      end
      tick();
      checks++; if (DM_CS !== m_busy) begin errors++; $display("FAIL rnd_cs c%0d got %b want %b", c, DM_CS, m_busy); end
      checks++; if (DM_R !== (m_busy && !m_we)) begin errors++; $display("FAIL rnd_r c%0d got %b want %b", c, DM_R, m_busy && !m_we); end
      checks++; if (DM_W !== (m_busy && m_we)) begin errors++; $display("FAIL rnd_w c%0d got %b want %b", c, DM_W, m_busy && m_we); end
      checks++; if (busy !== m_busy) begin errors++; $display("FAIL rnd_busy c%0d got %b want %b", c, busy, m_busy); end
      checks++; if (owner_b !== m_ob) begin errors++; $display("FAIL rnd_owner c%0d got %b want %b", c, owner_b, m_ob); end
      checks++; if (DM_addr !== m_addr) begin errors++; $display("FAIL rnd_addr c%0d got %h want %h", c, DM_addr, m_addr); end
      checks++; if (DM_wdata !== m_wdata) begin errors++; $display("FAIL rnd_wdata c%0d got %h want %h", c, DM_wdata, m_wdata); end
      checks++; if ({a_done, b_done} !== {m_ad, m_bd}) begin errors++; $display("FAIL rnd_done c%0d got %b want %b", c, {a_done, b_done}, {m_ad, m_bd}); end
      checks++; if (a_rdata !== m_ard) begin errors++; $display("FAIL rnd_ardata c%0d got %h want %h", c, a_rdata, m_ard); end
      checks++; if (b_rdata !== m_brd) begin errors++; $display("FAIL rnd_brdata c%0d got %h want %h", c, b_rdata, m_brd); end
      if (m_ad) begin
        if ($urandom_range(1) == 0) begin
          apend = 0; a_req = 0;
        end else begin
          a_we = $urandom_range(1); a_addr = $urandom_range(63); a_wdata = $urandom;
        end
      end
      if (m_bd) begin
        if ($urandom_range(1) == 0) begin
          bpend = 0; b_req = 0;
        end else begin
          b_we = $urandom_range(1); b_addr = $urandom_range(63); b_wdata = $urandom;
        end
      end
    end
    a_req = 0; b_req = 0;
    repeat (3) tick();
    for (int i = 0; i < 64; i++) if (mem[i] !== ref_mem[i]) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL rnd_mem got %0d bad words want 0", bad); end
  endtask

  task automatic test_idle_hold();
    logic [31:0] start_addr;
    start_addr = m_addr;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++; if ({DM_CS, busy} !== 2'b00) begin errors++; $display("FAIL idle_cs%0d got %b want 00", i, {DM_CS, busy}); end
      checks++; if (DM_addr !== start_addr) begin errors++; $display("FAIL idle_addr%0d got %h want %h", i, DM_addr, start_addr); end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single_read();
    test_back_to_back();
    test_starvation();
    test_simultaneous();
    test_reset_mid_write();
    test_random();
    test_idle_hold();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
